mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Shares the single core memory bus between instruction fetch and the memory-access stage (loads and stores).
- Fixed data-over-fetch priority, with a starvation guard for fetch.
- One outstanding transaction at a time, registered outputs.
- A watchdog aborts transactions the memory never acknowledges and flags a bus error.

Parameters:
- STARVE_LIMIT, 4: consecutive data grants allowed while fetch is pending before fetch is forced; minimum 1.
- TIMEOUT, 255: maximum BUSY cycles waiting for mem_ready before abort; 0 disables the watchdog.

Ports:
- clk  in  1  core clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- fetch_valid  in  1  fetch request; held with fetch_addr until fetch_ready.
- fetch_addr  in  32  fetch word address.
- fetch_ready  out  1  one-cycle completion pulse to fetch.
- fetch_rdata  out  32  instruction word, valid while fetch_ready=1.
- data_valid  in  1  load/store request; held with payload until data_ready.
- data_addr  in  32  load/store address.
- data_wdata  in  32  store data.
- data_wstrb  in  4  byte strobes; 0 = load.
- data_ready  out  1  one-cycle completion pulse to the accessor.
- data_rdata  out  32  load data, valid while data_ready=1.
- mem_valid  out  1  bus request.
- mem_instr  out  1  1 = current transaction is a fetch.
- mem_addr  out  32  bus address.
- mem_wdata  out  32  bus write data.
- mem_wstrb  out  4  bus byte strobes.
- mem_ready  in  1  bus acknowledge; mem_rdata valid in the same cycle.
- mem_rdata  in  32  bus read data.
- bus_error  out  1  one-cycle pulse: transaction aborted by the watchdog.
- error_is_data  out  1  source of the last bus_error (1 = data); holds until the next error.

Behaviour:
- Reset (reset=0, asynchronous): state IDLE; all outputs 0; starve and timeout counters 0.
- States:
  - IDLE -> BUSY on any request valid.
  - BUSY -> RESP on mem_ready or timeout.
  - RESP -> IDLE unconditionally.
- Grant in IDLE:
  - Data wins when both are valid, unless starve_cnt == STARVE_LIMIT, in which case fetch wins.
  - On a grant, register payload into mem_* and set mem_valid=1 in the next cycle (BUSY), so request-to-mem_valid latency is 1 cycle.
  - Fetch grant drives mem_instr=1, mem_wstrb=0, mem_wdata=0.
- Starvation counter:
  - A data grant while fetch_valid=1 increments starve_cnt, saturating at STARVE_LIMIT.
  - A fetch grant, or a data grant with fetch_valid=0, clears it.
- BUSY:
  - mem_* held stable.
  - The timeout counter increments each cycle mem_ready=0.
  - On mem_ready=1: capture mem_rdata into the granted requester's rdata, drop mem_valid at the next edge, enter RESP.
  - mem_ready in the first BUSY cycle is legal, giving a 2-cycle minimum transaction: BUSY, RESP.
- Timeout (TIMEOUT>0): when the counter reaches TIMEOUT with mem_ready still 0:
  - drop mem_valid and enter RESP;
  - rdata = 0;
  - bus_error=1 for the RESP cycle;
  - error_is_data updated.
  - mem_ready arriving in the same cycle as the timeout wins: normal completion, no error.
- RESP:
  - Granted requester's ready=1 for exactly one cycle; rdata is held.
  - mem_valid=0; no new grant is made.
  - This dead cycle lets the requester drop or advance valid before the next arbitration.
- The ungranted requester's ready is always 0.
- rdata outputs hold their last value outside RESP.
- Requests deasserted mid-transaction are ignored: the transaction completes and ready still pulses.
- mem_ready outside BUSY is ignored.
- Reset asserted mid-BUSY: mem_valid drops immediately and no ready or error pulse is produced.
- Throughput: at most one transaction per 3 cycles (IDLE, BUSY, RESP).

Test Plan:
- Single fetch, addr 0x100, memory acks 1 cycle after mem_valid with 0x00000013 -> mem_valid for 2 cycles, mem_instr=1, mem_wstrb=0; fetch_ready pulse with fetch_rdata=0x00000013; data_ready stays 0.
- Both valid in the same cycle (store addr 0x2000, wdata 0xDEADBEEF, wstrb 4'b1111) -> data granted first with mem_instr=0; fetch granted after data's RESP cycle.
- data_valid and fetch_valid held high continuously, STARVE_LIMIT=4 -> grant order D,D,D,D,F,D,D,D,D,F.
- mem_ready never asserted, TIMEOUT=8, load request -> mem_valid drops after 8 BUSY cycles; bus_error pulses once; error_is_data=1; data_ready pulses with data_rdata=0.
- mem_ready asserted in the exact cycle the timeout counter hits TIMEOUT -> normal completion, bus_error stays 0.
- reset pulled low during BUSY of a fetch -> mem_valid=0 immediately, no fetch_ready; after release a pending data request is granted normally.

Source files
------------

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares the single core memory bus between instruction fetch
// and the load/store stage.
//   - Data has priority over fetch. A starvation counter forces a fetch grant
//     after STARVE_LIMIT consecutive data grants made while fetch was waiting.
//   - Only one transaction is outstanding at a time, and all outputs are
//     registered. Each transaction runs IDLE -> BUSY -> RESP.
//   - A watchdog aborts a transaction after TIMEOUT unacknowledged BUSY
//     cycles and raises bus_error. Setting TIMEOUT to 0 disables it.
// Ports:
//   clk, reset (async, active-low)
//   fetch_valid/fetch_addr   -> fetch_ready/fetch_rdata
//   data_valid/data_addr/data_wdata/data_wstrb -> data_ready/data_rdata
//   mem_valid/mem_instr/mem_addr/mem_wdata/mem_wstrb <- mem_ready/mem_rdata
//   bus_error (pulse), error_is_data (source of the last error)
module mem_arbiter #(
  parameter int STARVE_LIMIT = 4,
  parameter int TIMEOUT      = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        fetch_valid,
  input  logic [31:0] fetch_addr,
  output logic        fetch_ready,
  output logic [31:0] fetch_rdata,
  input  logic        data_valid,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  input  logic [3:0]  data_wstrb,
  output logic        data_ready,
  output logic [31:0] data_rdata,
  output logic        mem_valid,
  output logic        mem_instr,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata,
  output logic        bus_error,
  output logic        error_is_data
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  localparam int SW = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

  logic [1:0]    state;
  logic [SW-1:0] starve_cnt;
  logic [TW-1:0] tcnt;
  logic          granted_data;

  logic starved;
  logic grant_fetch;
  logic timeout_hit;
  logic done;
  logic [31:0] done_rdata;

  // Fetch wins only when data is idle or fetch has been starved long enough.
  assign starved     = (starve_cnt == SW'(STARVE_LIMIT));
  assign grant_fetch = fetch_valid && (!data_valid || starved);

  // The counter starts at 0 in the first BUSY cycle. The abort therefore
  // fires at the end of the TIMEOUT-th unacknowledged cycle. If mem_ready
  // arrives in that same cycle, the transaction completes normally instead.
  assign timeout_hit = (TIMEOUT != 0) && (tcnt == TW'(TIMEOUT - 1)) && !mem_ready;
  assign done        = mem_ready || timeout_hit;
  assign done_rdata  = mem_ready ? mem_rdata : 32'h0;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= IDLE;
      starve_cnt    <= '0;
      tcnt          <= '0;
      granted_data  <= 1'b0;
      fetch_ready   <= 1'b0;
      fetch_rdata   <= 32'h0;
      data_ready    <= 1'b0;
      data_rdata    <= 32'h0;
      mem_valid     <= 1'b0;
      mem_instr     <= 1'b0;
      mem_addr      <= 32'h0;
      mem_wdata     <= 32'h0;
      mem_wstrb     <= 4'h0;
      bus_error     <= 1'b0;
      error_is_data <= 1'b0;
    end else begin
      fetch_ready <= 1'b0;
      data_ready  <= 1'b0;
      bus_error   <= 1'b0;
      case (state)
        IDLE: begin
          if (fetch_valid || data_valid) begin
            state     <= BUSY;
            mem_valid <= 1'b1;
            tcnt      <= '0;
            if (grant_fetch) begin
              granted_data <= 1'b0;
              mem_instr    <= 1'b1;
              mem_addr     <= fetch_addr;
              mem_wdata    <= 32'h0;
              mem_wstrb    <= 4'h0;
              starve_cnt   <= '0;
            end else begin
              granted_data <= 1'b1;
              mem_instr    <= 1'b0;
              mem_addr     <= data_addr;
              mem_wdata    <= data_wdata;
              mem_wstrb    <= data_wstrb;
              // Only a data grant made while fetch is waiting counts as starving it.
              if (!fetch_valid)
                starve_cnt <= '0;
              else if (!starved)
                starve_cnt <= starve_cnt + SW'(1);
            end
          end
        end
        BUSY: begin
          if (done) begin
            state     <= RESP;
            mem_valid <= 1'b0;
            if (granted_data) begin
              data_ready <= 1'b1;
              data_rdata <= done_rdata;
            end else begin
              fetch_ready <= 1'b1;
              fetch_rdata <= done_rdata;
            end
            if (timeout_hit) begin
              bus_error     <= 1'b1;
              error_is_data <= granted_data;
            end
          end else begin
            tcnt <= tcnt + TW'(1);
          end
        end
        RESP: begin
          // This dead cycle gives the requester time to drop or advance its valid.
          state <= IDLE;
        end
        default: begin
          state     <= IDLE;
          mem_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed bench for mem_arbiter (STARVE_LIMIT=4, TIMEOUT=8).
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        fetch_valid;
  logic [31:0] fetch_addr;
  logic        fetch_ready;
  logic [31:0] fetch_rdata;
  logic        data_valid;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic [3:0]  data_wstrb;
  logic        data_ready;
  logic [31:0] data_rdata;
  logic        mem_valid;
  logic        mem_instr;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_ready;
  logic [31:0] mem_rdata;
  logic        bus_error;
  logic        error_is_data;

  int checks = 0;
  int errors = 0;

  mem_arbiter #(.STARVE_LIMIT(4), .TIMEOUT(8)) dut (
    .clk(clk), .reset(reset),
    .fetch_valid(fetch_valid), .fetch_addr(fetch_addr),
    .fetch_ready(fetch_ready), .fetch_rdata(fetch_rdata),
    .data_valid(data_valid), .data_addr(data_addr), .data_wdata(data_wdata),
    .data_wstrb(data_wstrb), .data_ready(data_ready), .data_rdata(data_rdata),
    .mem_valid(mem_valid), .mem_instr(mem_instr), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata),
    .bus_error(bus_error), .error_is_data(error_is_data)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: observed=hung expected=finished");
    $fatal(1, "simulation time limit");
  end

  initial begin
    int n;
    logic exp_instr;
    reset = 1'b0; fetch_valid = 1'b0; fetch_addr = 32'h0;
    data_valid = 1'b0; data_addr = 32'h0; data_wdata = 32'h0; data_wstrb = 4'h0;
    mem_ready = 1'b0; mem_rdata = 32'h0;
    step(); step();
    // Reset state
    chk("rst_mem_valid", {31'h0, mem_valid}, 32'h0);
    chk("rst_fetch_ready", {31'h0, fetch_ready}, 32'h0);
    chk("rst_data_ready", {31'h0, data_ready}, 32'h0);
    chk("rst_bus_error", {31'h0, bus_error}, 32'h0);
    chk("rst_error_is_data", {31'h0, error_is_data}, 32'h0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    reset = 1'b1;
    step();

    // Single fetch, ack one cycle after mem_valid
    fetch_valid = 1'b1; fetch_addr = 32'h100;
    step();
    chk("f1_mem_valid", {31'h0, mem_valid}, 32'h1);
    chk("f1_mem_instr", {31'h0, mem_instr}, 32'h1);
    chk("f1_mem_addr", mem_addr, 32'h100);
    chk("f1_mem_wstrb", {28'h0, mem_wstrb}, 32'h0);
    chk("f1_mem_wdata", mem_wdata, 32'h0);
    step();
    chk("f1_mem_valid_2nd", {31'h0, mem_valid}, 32'h1);
    chk("f1_fetch_ready_early", {31'h0, fetch_ready}, 32'h0);
    mem_ready = 1'b1; mem_rdata = 32'h00000013;
    step();
    chk("f1_resp_mem_valid", {31'h0, mem_valid}, 32'h0);
    chk("f1_fetch_ready", {31'h0, fetch_ready}, 32'h1);
    chk("f1_fetch_rdata", fetch_rdata, 32'h00000013);
    chk("f1_data_ready", {31'h0, data_ready}, 32'h0);
    mem_ready = 1'b0; fetch_valid = 1'b0;
    step();
    chk("f1_ready_drop", {31'h0, fetch_ready}, 32'h0);
    chk("f1_rdata_hold", fetch_rdata, 32'h00000013);

    // Both valid: data first, then fetch after data's RESP
    fetch_valid = 1'b1; fetch_addr = 32'h100;
    data_valid = 1'b1; data_addr = 32'h2000; data_wdata = 32'hDEADBEEF; data_wstrb = 4'hF;
    step();
    chk("both_mem_instr", {31'h0, mem_instr}, 32'h0);
    chk("both_mem_addr", mem_addr, 32'h2000);
    chk("both_mem_wdata", mem_wdata, 32'hDEADBEEF);
    chk("both_mem_wstrb", {28'h0, mem_wstrb}, 32'hF);
    mem_ready = 1'b1; mem_rdata = 32'hCAFEF00D;
    step();
    chk("both_data_ready", {31'h0, data_ready}, 32'h1);
    chk("both_fetch_ready", {31'h0, fetch_ready}, 32'h0);
    chk("both_data_rdata", data_rdata, 32'hCAFEF00D);
    chk("both_resp_no_grant", {31'h0, mem_valid}, 32'h0);
    mem_ready = 1'b0; data_valid = 1'b0;
    step();
    chk("both_idle_mem_valid", {31'h0, mem_valid}, 32'h0);
    step();
    chk("both_fetch_grant", {31'h0, mem_valid & mem_instr}, 32'h1);
    chk("both_fetch_addr", mem_addr, 32'h100);
    mem_ready = 1'b1; mem_rdata = 32'h11111111;
    step();
    chk("both_fetch_ready2", {31'h0, fetch_ready}, 32'h1);
    mem_ready = 1'b0; fetch_valid = 1'b0;
    step();

    // Starvation guard: both held, expect D,D,D,D,F,D,D,D,D,F
    fetch_valid = 1'b1; data_valid = 1'b1; data_wstrb = 4'h0;
    for (int i = 0; i < 10; i++) begin
      n = 0;
      while (!mem_valid && n < 5) begin
        step();
        n++;
      end
      chk($sformatf("starve_wait_%0d", i), {31'h0, mem_valid}, 32'h1);
      exp_instr = (i == 4 || i == 9);
      chk($sformatf("starve_grant_%0d", i), {31'h0, mem_instr}, {31'h0, exp_instr});
      mem_ready = 1'b1; mem_rdata = 32'h1000 + i;
      step();
      mem_ready = 1'b0;
      step();
    end
    fetch_valid = 1'b0; data_valid = 1'b0;
    step(); step();

    // Watchdog: load never acknowledged, TIMEOUT=8
    data_valid = 1'b1; data_addr = 32'h3000; data_wstrb = 4'h0;
    step();
    for (int k = 1; k <= 8; k++) begin
      chk($sformatf("to_busy_%0d", k), {31'h0, mem_valid}, 32'h1);
      chk($sformatf("to_noerr_%0d", k), {31'h0, bus_error}, 32'h0);
      step();
    end
    data_valid = 1'b0;
    chk("to_mem_valid_drop", {31'h0, mem_valid}, 32'h0);
    chk("to_bus_error", {31'h0, bus_error}, 32'h1);
    chk("to_error_is_data", {31'h0, error_is_data}, 32'h1);
    chk("to_data_ready", {31'h0, data_ready}, 32'h1);
    chk("to_data_rdata", data_rdata, 32'h0);
    step();
    chk("to_bus_error_pulse", {31'h0, bus_error}, 32'h0);
    chk("to_error_is_data_hold", {31'h0, error_is_data}, 32'h1);

    // mem_ready in the exact timeout cycle wins (fetch)
    fetch_valid = 1'b1; fetch_addr = 32'h400;
    step();
    for (int k = 0; k < 7; k++) step();
    chk("race_still_busy", {31'h0, mem_valid}, 32'h1);
    mem_ready = 1'b1; mem_rdata = 32'h0000600D;
    step();
    chk("race_no_error", {31'h0, bus_error}, 32'h0);
    chk("race_fetch_ready", {31'h0, fetch_ready}, 32'h1);
    chk("race_fetch_rdata", fetch_rdata, 32'h0000600D);
    chk("race_error_is_data", {31'h0, error_is_data}, 32'h1);
    mem_ready = 1'b0; fetch_valid = 1'b0;
    step();

    // Reset mid-BUSY of a fetch, then a pending data request
    fetch_valid = 1'b1; fetch_addr = 32'h500;
    step();
    chk("rb_busy", {31'h0, mem_valid & mem_instr}, 32'h1);
    fetch_valid = 1'b0;
    data_valid = 1'b1; data_addr = 32'h6000; data_wstrb = 4'h3; data_wdata = 32'h12345678;
    #2 reset = 1'b0;
    #1;
    chk("rb_mem_valid_async", {31'h0, mem_valid}, 32'h0);
    chk("rb_fetch_ready", {31'h0, fetch_ready}, 32'h0);
    chk("rb_error_is_data", {31'h0, error_is_data}, 32'h0);
    step();
    reset = 1'b1;
    step();
    chk("rb_no_fetch_ready", {31'h0, fetch_ready}, 32'h0);
    chk("rb_data_grant", {31'h0, mem_valid}, 32'h1);
    chk("rb_data_instr", {31'h0, mem_instr}, 32'h0);
    chk("rb_data_addr", mem_addr, 32'h6000);
    chk("rb_data_wstrb", {28'h0, mem_wstrb}, 32'h3);
    mem_ready = 1'b1; mem_rdata = 32'hABCD0001;
    step();
    chk("rb_data_ready", {31'h0, data_ready}, 32'h1);
    chk("rb_data_rdata", data_rdata, 32'hABCD0001);
    mem_ready = 1'b0; data_valid = 1'b0;
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
